// File: rtl/at24c02_arb.sv
// at24c02_arb: round-robin arbiter and burst sequencer for a shared at24c02_ctl.
// Grants one 1..16 byte burst at a time, splits write bursts at page ends.
module at24c02_arb #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned PAGE_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*4-1:0]      req_len,
    input  logic [N_REQ*8-1:0]      req_wdata,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        wdata_ack,
    output logic [7:0]              rdata,
    output logic [N_REQ-1:0]        rdata_valid,
    output logic [N_REQ-1:0]        req_done,
    output logic [ADDR_W-1:0]       ctl_address,
    output logic [7:0]              ctl_din,
    output logic                    ctl_wr_en,
    output logic                    ctl_parent_ready,
    output logic                    ctl_last,
    input  logic [7:0]              ctl_dout,
    input  logic                    ctl_ready
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PAGE_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int unsigned REM_W  = 5;

    typedef enum logic [1:0] {IDLE, XFER, GAP, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic               wr;
    logic [ADDR_W-1:0]  cur_addr;
    logic [REM_W-1:0]   remaining;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    int unsigned        cand;
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [3:0]         sel_len;

    // First requesting index at or after rr_ptr, wrapping
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!pick_vld && req_valid[IDX_W'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    // Request fields of the arbitration winner
    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_wr   = req_wr[i];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*4 +: 4];
            end
        end
    end

    // Write data of the current owner; zero while idle
    always_comb begin
        ctl_din = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) ctl_din = req_wdata[i*8 +: 8];
        end
    end

    // Segment ends on the final byte, or on a page's last byte for writes
    always_comb begin
        ctl_last = (state == XFER) &&
                   ((remaining == REM_W'(1)) || (wr && (&cur_addr[PAGE_W-1:0])));
    end

    // Burst sequencer; ctl_address holds the start of the current segment
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant            <= '0;
            wr               <= 1'b0;
            cur_addr         <= '0;
            remaining        <= '0;
            wdata_ack        <= '0;
            rdata_valid      <= '0;
            req_done         <= '0;
            rdata            <= '0;
            ctl_address      <= '0;
            ctl_wr_en        <= 1'b0;
            ctl_parent_ready <= 1'b0;
        end else begin
            wdata_ack   <= '0;
            rdata_valid <= '0;
            req_done    <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant            <= N_REQ'(1) << pick_idx;
                        wr               <= sel_wr;
                        cur_addr         <= sel_addr;
                        remaining        <= REM_W'(sel_len) + REM_W'(1);
                        rr_ptr           <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0
                                                                             : pick_idx + IDX_W'(1);
                        ctl_address      <= sel_addr;
                        ctl_wr_en        <= sel_wr;
                        ctl_parent_ready <= 1'b1;
                        state            <= XFER;
                    end
                end
                XFER: begin
                    if (ctl_ready) begin
                        if (wr) begin
                            wdata_ack <= grant;
                        end else begin
                            rdata       <= ctl_dout;
                            rdata_valid <= grant;
                        end
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        remaining <= remaining - REM_W'(1);
                        if (ctl_last) begin
                            ctl_parent_ready <= 1'b0;
                            if (remaining == REM_W'(1)) begin
                                req_done <= grant;
                                state    <= DONE;
                            end else begin
                                ctl_address <= cur_addr + ADDR_W'(1);
                                state       <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    ctl_parent_ready <= 1'b1;
                    state            <= XFER;
                end
                DONE: begin
                    grant       <= '0;
                    ctl_wr_en   <= 1'b0;
                    ctl_address <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_at24c02_arb.sv
// tb_at24c02_arb: scoreboard bench with a behavioural EEPROM controller model.
module tb_at24c02_arb;

    localparam int N  = 2;
    localparam int AW = 11;

    localparam int K_SEG  = 0;
    localparam int K_LAST = 1;
    localparam int K_ACK  = 2;
    localparam int K_RD   = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int kind;
        int req;
        int val;
    } ev_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*4-1:0]  req_len;
    logic [N*8-1:0]  req_wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    wdata_ack;
    logic [7:0]      rdata;
    logic [N-1:0]    rdata_valid;
    logic [N-1:0]    req_done;
    logic [AW-1:0]   ctl_address;
    logic [7:0]      ctl_din;
    logic            ctl_wr_en;
    logic            ctl_parent_ready;
    logic            ctl_last;
    logic [7:0]      ctl_dout;
    logic            ctl_ready;

    at24c02_arb #(.N_REQ(N), .ADDR_W(AW), .PAGE_BYTES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .grant(grant), .wdata_ack(wdata_ack), .rdata(rdata),
        .rdata_valid(rdata_valid), .req_done(req_done),
        .ctl_address(ctl_address), .ctl_din(ctl_din), .ctl_wr_en(ctl_wr_en),
        .ctl_parent_ready(ctl_parent_ready), .ctl_last(ctl_last),
        .ctl_dout(ctl_dout), .ctl_ready(ctl_ready)
    );

    ev_t        q[$];
    int         n_cmp;
    int         n_fail;
    bit         mon_en;
    logic [7:0] vec   [16];
    logic [7:0] wbuf  [N][16];
    int         wptr  [N];
    int         reps  [N];
    logic [7:0] mem   [2048];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard pop and compare
    task automatic check_ev(input int kind, input int req, input int val);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d req=%0d val=0x%0h at %0t", kind, req, val, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.req != req || e.val != val) begin
                n_fail++;
                $display("FAIL event got kind=%0d req=%0d val=0x%0h want kind=%0d req=%0d val=0x%0h at %0t",
                         kind, req, val, e.kind, e.req, e.val, $time);
            end
        end
    endtask

    // Controller model: ready pulses 2 cycles apart, page wrap on writes
    initial begin
        logic [AW-1:0] caddr;
        bit            cwr;
        bit            busy;
        bit            lst;
        for (int a = 0; a < 2048; a++) mem[a] = pat(a);
        ctl_ready = 1'b0;
        ctl_dout  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (ctl_parent_ready) begin
                caddr = ctl_address;
                cwr   = ctl_wr_en;
                busy  = 1'b1;
                while (busy) begin
                    repeat (2) begin @(posedge clk); #1; end
                    if (!ctl_parent_ready) begin
                        busy = 1'b0;
                    end else begin
                        lst = ctl_last;
                        if (cwr) mem[caddr] = ctl_din;
                        else     ctl_dout   = mem[caddr];
                        ctl_ready = 1'b1;
                        @(posedge clk); #1;
                        ctl_ready = 1'b0;
                        if (cwr) caddr = {caddr[AW-1:3], caddr[2:0] + 3'd1};
                        else     caddr = caddr + 11'd1;
                        if (lst) begin
                            busy = 1'b0;
                            while (ctl_parent_ready) begin @(posedge clk); #1; end
                        end
                    end
                end
            end
        end
    end

    // Monitor: turns DUT output activity into events for the scoreboard
    initial begin
        bit         prev_pr;
        logic [N-1:0] prev_grant;
        int         low_run;
        logic [7:0] last_din;
        prev_pr = 1'b0; prev_grant = '0; low_run = 0; last_din = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ctl_parent_ready && !prev_pr) begin
                    check_ev(K_SEG, oh2i(grant), int'(ctl_address) | (int'(ctl_wr_en) << 11));
                    if (prev_grant != '0) chk("gap_len", low_run, 1);
                end
                if (ctl_ready && ctl_parent_ready && ctl_last) check_ev(K_LAST, oh2i(grant), 0);
                if (ctl_ready && ctl_parent_ready && ctl_wr_en) last_din = ctl_din;
                if (|wdata_ack)   check_ev(K_ACK, oh2i(wdata_ack), int'(last_din));
                if (|rdata_valid) check_ev(K_RD, oh2i(rdata_valid), int'(rdata));
                if (|req_done)    check_ev(K_DONE, oh2i(req_done), 0);
            end
            low_run    = ctl_parent_ready ? 0 : low_run + 1;
            prev_pr    = ctl_parent_ready;
            prev_grant = grant;
        end
    end

    // One clock step plus the client-side reaction to acks and done
    task automatic tick();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (wdata_ack[i]) begin
                if (wptr[i] < 15) wptr[i]++;
                req_wdata[i*8 +: 8] = wbuf[i][wptr[i]];
            end
            if (req_done[i]) begin
                if (reps[i] > 0) begin
                    reps[i]--;
                    wptr[i] = 0;
                    req_wdata[i*8 +: 8] = wbuf[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Expected events for one burst; data comes from vec
    task automatic push_burst(input int i, input bit w, input int addr, input int len);
        int a;
        bit lst;
        q.push_back('{K_SEG, i, addr | (int'(w) << 11)});
        for (int k = 0; k <= len; k++) begin
            a   = (addr + k) & 'h7FF;
            lst = (k == len) || (w && ((a & 7) == 7));
            if (lst) q.push_back('{K_LAST, i, 0});
            q.push_back('{w ? K_ACK : K_RD, i, int'(vec[k])});
            if (lst && k < len) q.push_back('{K_SEG, i, ((a + 1) & 'h7FF) | (int'(w) << 11)});
        end
        q.push_back('{K_DONE, i, 0});
    endtask

    task automatic start(input int i, input bit w, input int addr, input int len);
        for (int k = 0; k < 16; k++) wbuf[i][k] = vec[k];
        wptr[i] = 0;
        req_wr[i] = w;
        req_addr[i*AW +: AW] = AW'(addr);
        req_len[i*4 +: 4] = 4'(len);
        req_wdata[i*8 +: 8] = vec[0];
        req_valid[i] = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d", q.size());
            q.delete();
        end
        idle(3);
    endtask

    task automatic load_seq(input int base, input int n);
        for (int k = 0; k < 16; k++) vec[k] = (k < n) ? 8'(base + k) : 8'h00;
    endtask

    task automatic load_pat(input int addr, input int n);
        for (int k = 0; k < 16; k++) vec[k] = (k < n) ? pat((addr + k) & 'h7FF) : 8'h00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_wdata_ack"}, int'(wdata_ack), 0);
        chk({tag, "_rdata_valid"}, int'(rdata_valid), 0);
        chk({tag, "_req_done"}, int'(req_done), 0);
        chk({tag, "_rdata"}, int'(rdata), 0);
        chk({tag, "_ctl_address"}, int'(ctl_address), 0);
        chk({tag, "_ctl_din"}, int'(ctl_din), 0);
        chk({tag, "_ctl_wr_en"}, int'(ctl_wr_en), 0);
        chk({tag, "_ctl_pr"}, int'(ctl_parent_ready), 0);
        chk({tag, "_ctl_last"}, int'(ctl_last), 0);
    endtask

    initial begin
        int n;
        n_cmp = 0; n_fail = 0; mon_en = 1'b0;
        rst = 1'b1;
        req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            wptr[i] = 0;
            reps[i] = 0;
            for (int k = 0; k < 16; k++) wbuf[i][k] = 8'h00;
        end
        for (int k = 0; k < 16; k++) vec[k] = 8'h00;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Both requesters from reset, each re-requesting once: 0,1,0,1
        load_pat('h300, 2); push_burst(0, 1'b0, 'h300, 1); start(0, 1'b0, 'h300, 1);
        load_pat('h310, 2); push_burst(1, 1'b0, 'h310, 1); start(1, 1'b0, 'h310, 1);
        load_pat('h300, 2); push_burst(0, 1'b0, 'h300, 1);
        load_pat('h310, 2); push_burst(1, 1'b0, 'h310, 1);
        reps[0] = 1; reps[1] = 1;
        drain();
        chk("rr_valid_cleared", int'(req_valid), 0);

        // 8-byte write in one page, grant latency, then read-back
        load_seq('h10, 8); push_burst(0, 1'b1, 'h080, 7); start(0, 1'b1, 'h080, 7);
        tick();
        chk("grant_latency", int'(grant), 1);
        chk("pr_latency", int'(ctl_parent_ready), 1);
        drain();
        load_seq('h10, 8); push_burst(0, 1'b0, 'h080, 7); start(0, 1'b0, 'h080, 7);
        drain();

        // 6-byte write across a page end: segments 0x005 and 0x008
        load_seq('hA0, 6); push_burst(1, 1'b1, 'h005, 5); start(1, 1'b1, 'h005, 5);
        drain();
        load_seq('hA0, 6); push_burst(1, 1'b0, 'h005, 5); start(1, 1'b0, 'h005, 5);
        drain();

        // 16-byte read across a page: never split
        load_pat('h0F8, 16); push_burst(0, 1'b0, 'h0F8, 15); start(0, 1'b0, 'h0F8, 15);
        drain();

        // Request inputs change after grant: latched values win
        load_seq('h31, 4); push_burst(0, 1'b1, 'h040, 3); start(0, 1'b1, 'h040, 3);
        n = 0;
        while (!wdata_ack[0] && n < 200) begin tick(); n++; end
        chk("mid_first_ack_seen", int'(wdata_ack[0]), 1);
        req_valid[0] = 1'b0;
        req_addr[0 +: AW] = 11'h123;
        req_len[0 +: 4] = 4'd0;
        req_wr[0] = 1'b0;
        drain();
        load_seq('h31, 4); push_burst(1, 1'b0, 'h040, 3); start(1, 1'b0, 'h040, 3);
        drain();

        // Reset during the 3rd byte of a write
        load_seq('h50, 5);
        q.push_back('{K_SEG, 0, 'h060 | (1 << 11)});
        q.push_back('{K_ACK, 0, 'h50});
        q.push_back('{K_ACK, 0, 'h51});
        start(0, 1'b1, 'h060, 4);
        n = 0;
        for (int t = 0; t < 300 && n < 2; t++) begin
            tick();
            if (wdata_ack[0]) n++;
        end
        chk("rst_two_acks", n, 2);
        rst = 1'b1;
        req_valid = '0;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        idle(10);
        chk("no_done_after_rst", q.size(), 0);
        q.delete();

        // Normal service after reset, then read-back
        load_seq('h61, 3); push_burst(1, 1'b1, 'h200, 2); start(1, 1'b1, 'h200, 2);
        drain();
        load_seq('h61, 3); push_burst(0, 1'b0, 'h200, 2); start(0, 1'b0, 'h200, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/at24c02_arb.md
# at24c02_arb

Round-robin arbiter and burst sequencer sharing one `at24c02_ctl` I2C master between `N_REQ` requesters. Each requester submits a 1–16-byte read or write burst. The block grants one burst at a time and drives the controller's `address/din/wr_en/parent_ready/last` handshake. It splits write bursts at EEPROM page boundaries so sequential writes never wrap inside a page. It sits between client logic and `at24c02_ctl`; the I2C pins stay on the controller.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `ADDR_W`, 11, EEPROM byte-address width (matches `at24c02_ctl.address`)
- `PAGE_BYTES`, 8, write-page size; power of two
- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in N_REQ — burst request per requester; level, held until `req_done[i]`
- `req_wr` in N_REQ — 1 = write burst, 0 = read burst
- `req_addr` in N_REQ*ADDR_W — start address, packed, requester i at `[i*ADDR_W +: ADDR_W]`
- `req_len` in N_REQ*4 — byte count minus 1 (0 → 1 byte, 15 → 16 bytes)
- `req_wdata` in N_REQ*8 — current write byte per requester
- `grant` out N_REQ — one-hot owner of the current burst; 0 when idle
- `wdata_ack` out N_REQ — 1-cycle pulse: current write byte consumed; next byte is due by the following cycle
- `rdata` out 8 — read byte, broadcast
- `rdata_valid` out N_REQ — 1-cycle pulse to the owner: `rdata` is valid
- `req_done` out N_REQ — 1-cycle pulse: burst finished
- `ctl_address` out ADDR_W, `ctl_din` out 8, `ctl_wr_en` out 1, `ctl_parent_ready` out 1, `ctl_last` out 1 — to controller
- `ctl_dout` in 8, `ctl_ready` in 1 — from controller; `ctl_ready` is a 1-cycle pulse per byte transferred

## Operation
- States: IDLE, XFER, GAP, DONE.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit at or after `rr_ptr`, wrapping.
  - Latch `wr`, `addr` into `cur_addr` and `len+1` into `remaining`; set `grant`; go to XFER.
  - `rr_ptr` becomes winner+1 mod N_REQ.
- **XFER**
  - Drive `ctl_parent_ready=1`, `ctl_address=seg_addr` (segment start), `ctl_wr_en=wr`.
  - `ctl_din` = granted requester's `req_wdata`, combinational mux.
  - `ctl_last` = (`remaining==1`) OR (`wr` AND `cur_addr[log2(PAGE_BYTES)-1:0]` all ones).
- **On `ctl_ready` in XFER**
  - Write: pulse `wdata_ack[g]`. Read: `rdata<=ctl_dout` and pulse `rdata_valid[g]` in the same cycle.
  - Then `cur_addr+=1` (mod 2^ADDR_W) and `remaining-=1`.
  - If `ctl_last` was 1 and `remaining` was 1: go to DONE.
  - Else if `ctl_last` was 1 (page end): `seg_addr<=cur_addr+1`; go to GAP.
- **GAP**: `ctl_parent_ready=0` for exactly 1 cycle, then back to XFER (new segment).
- **DONE**: `ctl_parent_ready=0`, pulse `req_done[g]`, clear `grant`, go to IDLE. This gives a 2-cycle bus-idle minimum between bursts.
- Reads are never split; the controller's sequential read crosses pages.
- Request inputs are sampled only at grant. Later changes to `req_addr`, `req_len` or `req_wr` are ignored. Deasserting `req_valid` mid-burst does not abort the burst.
- `ctl_ready` outside XFER is ignored.

## Timing
- Reset: state=IDLE, `rr_ptr=0`, `grant=0`, all pulses 0, `rdata=0`, all `ctl_*` outputs 0.
- Reset mid-burst drops `ctl_parent_ready` on the next edge, with no `req_done`. Clients must re-request.
- Grant latency: `req_valid` seen in IDLE → `grant` and `ctl_parent_ready` high on the next edge.
- Controller-facing outputs are registered except `ctl_din` and `ctl_last`, which are combinational from registered state.
- Per byte: the controller dictates timing. The block adds zero cycles within a segment, 1 cycle per page split, and 1 DONE cycle per burst.
- A request present in DONE is seen in the following IDLE cycle.

## Test plan
- Write 8 bytes, `addr=0x080`, bytes 0x10..0x17, requester 0.
  - Expect one segment, `ctl_last` only on the 8th byte, 8 `wdata_ack` pulses, 1 `req_done`.
  - Reading back with a read burst of `len=7` returns 0x10..0x17.
- Write 6 bytes at `addr=0x005`.
  - Expect segments at 0x005 (3 bytes) and 0x008 (3 bytes).
  - Expect a 1-cycle `ctl_parent_ready` gap between segments.
  - Read-back of 0x005..0x00A matches.
- Read 16 bytes at `0x0F8` in a single segment; `ctl_last` only on the 16th byte.
- Both requesters assert together from reset.
  - Requester 0 is served first, then 1.
  - With both re-asserting, the order alternates 1, 0, 1.
- `req_valid[0]` drops and `req_addr` changes mid-burst: burst completes with the latched address.
- Reset asserted during the 3rd byte of a write.
  - All outputs 0 the next cycle; no `req_done`.
  - A new request after reset is served normally.
